// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the pipelined add/sub unit.
package adder_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int chunk_w(int width, int stages);
    return width / stages;
  endfunction

  function automatic bit chunk_ok(int width, int stages);
    return (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One carry chunk of the pipelined adder; the a word doubles
// as the result word, lower chunks replaced by finished sums.
module adder_pipe_stage
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int IDX    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             valid,
  input  op_e              op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_q,
  output op_e              op_q,
  output logic             cout_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);
  localparam int LSB   = IDX * CHUNK;

  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] acc;

  always_comb begin
    sum = {1'b0, a[LSB +: CHUNK]}
        + {1'b0, b[LSB +: CHUNK]}
        + {{CHUNK{1'b0}}, cin};
    acc = a;
    acc[LSB +: CHUNK] = sum[CHUNK-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else if (en) valid_q <= valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      op_q   <= op;
      cout_q <= sum[CHUNK];
      a_q    <= acc;
      b_q    <= b;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/sub with valid/ready on both sides.
// Optional clamp on overflow/borrow: define ADDER_PIPE_SAT_EN.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] c,
  output logic           sat
);

  if (!chunk_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a multiple of STAGES");
  end

  logic             en;
  logic [STAGES:0]  v;
  logic [STAGES:0]  cy;
  op_e              o  [STAGES+1];
  logic [WIDTH-1:0] as [STAGES+1];
  logic [WIDTH-1:0] bs [STAGES+1];
  logic [WIDTH:0]   raw;
  logic [WIDTH:0]   res;
  logic             sat_r;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !reset;

  assign v[0]  = in_valid && in_ready;
  assign o[0]  = op_e'(op);
  assign cy[0] = op;
  assign as[0] = a;
  assign bs[0] = (o[0] == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_pipe_stage #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .IDX   (k)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .valid  (v[k]),
      .op     (o[k]),
      .cin    (cy[k]),
      .a      (as[k]),
      .b      (bs[k]),
      .valid_q(v[k+1]),
      .op_q   (o[k+1]),
      .cout_q (cy[k+1]),
      .a_q    (as[k+1]),
      .b_q    (bs[k+1])
    );
  end

  assign out_valid = v[STAGES];

  // Carry out of a subtract is the inverse of the borrow.
  assign raw = {(o[STAGES] == OP_SUB) ? ~cy[STAGES] : cy[STAGES],
                as[STAGES]};

  always_comb begin
    res   = raw;
    sat_r = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
    if (raw[WIDTH]) begin
      sat_r = 1'b1;
      res   = (o[STAGES] == OP_SUB) ? '0 : {1'b0, {WIDTH{1'b1}}};
    end
`endif
  end

  assign c   = out_valid ? res : '0;
  assign sat = out_valid && sat_r;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: vector table, directed handshake cases and
// a randomized scoreboard stream against an arithmetic model.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       in_valid, in_ready, op, out_valid, out_ready, sat;
  logic [7:0] a, b;
  logic [8:0] c;

  logic        w_in_valid, w_in_ready, w_op, w_out_valid, w_sat;
  logic        w_out_ready;
  logic [15:0] w_a, w_b;
  logic [16:0] w_c;

  logic       s_in_valid, s_in_ready, s_op, s_out_valid, s_sat;
  logic       s_out_ready;
  logic [7:0] s_a, s_b;
  logic [8:0] s_c;

  adder_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .sat(sat)
  );

  adder_pipe #(.WIDTH(16), .STAGES(4)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .a(w_a), .b(w_b),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .c(w_c), .sat(w_sat)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .c(s_c), .sat(s_sat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Result straight from the arithmetic: (a op b) mod 2^(w+1).
  function automatic void model(input int w, input bit o,
                                input int x, input int y,
                                output int ce, output bit se);
    int full;
    full = o ? x - y : x + y;
    ce   = full & ((1 << (w + 1)) - 1);
    se   = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
    if ((ce >> w) != 0) begin
      se = 1'b1;
      ce = o ? 0 : (1 << w) - 1;
    end
`endif
  endfunction

  typedef struct {
    bit o;
    int x;
    int y;
    int ec;
    bit es;
  } vec_t;

  vec_t tbl[7];

  task automatic send8(input bit o, input int x, input int y,
                       output int gc, output bit gs, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x[7:0]; b = y[7:0];
    out_ready = 1'b1;
    #1;
    check("accept8", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    gc = c; gs = sat;
  endtask

  task automatic send16(input bit o, input int x, input int y,
                        output int gc, output bit gs, output int lat);
    @(negedge clk);
    w_in_valid = 1'b1; w_op = o; w_a = x[15:0]; w_b = y[15:0];
    #1;
    check("accept16", w_in_ready, 1);
    @(negedge clk);
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    gc = w_c; gs = w_sat;
  endtask

  task automatic send1(input bit o, input int x, input int y,
                       output int gc, output bit gs, output int lat);
    @(negedge clk);
    s_in_valid = 1'b1; s_op = o; s_a = x[7:0]; s_b = y[7:0];
    #1;
    check("accept1", s_in_ready, 1);
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 1;
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    gc = s_c; gs = s_sat;
  endtask

  task automatic stream8(input int n, input bit directed,
                         input int st_lo, input int st_hi);
    int  q_c[$];
    bit  q_s[$];
    int  sent, got, cyc, prev_c, ec;
    bit  was_stall, es;
    sent = 0; got = 0; cyc = 0; prev_c = 0; was_stall = 0;
    while (got < n && cyc < n * 10 + 50) begin
      @(negedge clk);
      if (directed) begin
        out_ready = !(cyc >= st_lo && cyc < st_hi);
        in_valid  = sent < n;
        op = 1'b0; a = 8'(sent + 1); b = 8'(sent + 1);
      end else begin
        out_ready = $urandom_range(0, 99) < 70;
        in_valid  = (sent < n) && ($urandom_range(0, 99) < 70);
        op = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      end
      #1;
      if (was_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_c", c, prev_c);
      end
      was_stall = out_valid && !out_ready;
      if (was_stall) begin
        check("stall_in_ready", in_ready, 0);
        prev_c = c;
      end
      if (out_valid && out_ready) begin
        if (q_c.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("stream_c", c, q_c.pop_front());
          check("stream_sat", sat, q_s.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        model(8, op, int'(a), int'(b), ec, es);
        q_c.push_back(ec);
        q_s.push_back(es);
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("stream_count", got, n);
    check("stream_left", q_c.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gc, lat, ec;
    bit gs, es, seen;

`ifdef ADDER_PIPE_SAT_EN
    tbl[0] = '{0, 200, 100, 'h0FF, 1};
    tbl[1] = '{0, 'h0F, 'h01, 'h010, 0};
    tbl[2] = '{1, 5, 9, 'h000, 1};
    tbl[3] = '{1, 7, 7, 'h000, 0};
    tbl[4] = '{0, 3, 4, 'h007, 0};
    tbl[5] = '{0, 'hFF, 'hFF, 'h0FF, 1};
    tbl[6] = '{1, 'h80, 'h01, 'h07F, 0};
`else
    tbl[0] = '{0, 200, 100, 'h12C, 0};
    tbl[1] = '{0, 'h0F, 'h01, 'h010, 0};
    tbl[2] = '{1, 5, 9, 'h1FC, 0};
    tbl[3] = '{1, 7, 7, 'h000, 0};
    tbl[4] = '{0, 3, 4, 'h007, 0};
    tbl[5] = '{0, 'hFF, 'hFF, 'h1FE, 0};
    tbl[6] = '{1, 'h80, 'h01, 'h07F, 0};
`endif

    reset = 1'b1;
    in_valid = 0; op = 0; a = 0; b = 0; out_ready = 1;
    w_in_valid = 0; w_op = 0; w_a = 0; w_b = 0; w_out_ready = 1;
    s_in_valid = 0; s_op = 0; s_a = 0; s_b = 0; s_out_ready = 1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_sat", sat, 0);
    check("rst_w_valid", w_out_valid, 0);
    check("rst_s_valid", s_out_valid, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);

    foreach (tbl[i]) begin
      send8(tbl[i].o, tbl[i].x, tbl[i].y, gc, gs, lat);
      check($sformatf("vec%0d_lat", i), lat, 2);
      check($sformatf("vec%0d_c", i), gc, tbl[i].ec);
      check($sformatf("vec%0d_sat", i), gs, tbl[i].es);
    end

    stream8(4, 1'b1, 3, 6);

    // Two beats in flight, then reset: neither may ever emerge.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 0; a = 10; b = 20;
    #1;
    check("inflight_acc0", in_ready, 1);
    @(negedge clk);
    a = 30; b = 40;
    #1;
    check("inflight_acc1", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_c", c, 0);
    check("mid_rst_ready_up", in_ready, 1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("mid_rst_discard", seen, 0);

    stream8(300, 1'b0, 0, 0);

    send16(0, 'hFFFF, 'h0001, gc, gs, lat);
    check("w_lat", lat, 4);
`ifdef ADDER_PIPE_SAT_EN
    check("w_c", gc, 'h0FFFF);
    check("w_sat", gs, 1);
`else
    check("w_c", gc, 'h10000);
    check("w_sat", gs, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      int x, y;
      bit o;
      x = $urandom_range(0, 65535);
      y = $urandom_range(0, 65535);
      o = 1'($urandom);
      send16(o, x, y, gc, gs, lat);
      model(16, o, x, y, ec, es);
      check("w_rand_lat", lat, 4);
      check("w_rand_c", gc, ec);
      check("w_rand_sat", gs, es);
    end

    send1(0, 200, 100, gc, gs, lat);
    model(8, 0, 200, 100, ec, es);
    check("s_lat", lat, 1);
    check("s_c", gc, ec);
    check("s_sat", gs, es);
    for (int i = 0; i < 8; i++) begin
      int x, y;
      bit o;
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      o = 1'($urandom);
      send1(o, x, y, gc, gs, lat);
      model(8, o, x, y, ec, es);
      check("s_rand_lat", lat, 1);
      check("s_rand_c", gc, ec);
      check("s_rand_sat", gs, es);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit valid-gated adder.
- Adds or subtracts two WIDTH-bit unsigned operands.
- Splits the carry chain into STAGES registered chunks so wide operands close timing.
- Full valid/ready handshake on both sides. Sits between operand producers and any consumer that can apply backpressure.

Parameters:
- WIDTH, 8: operand width in bits. Must be a multiple of STAGES.
- STAGES, 2: pipeline depth, which is also the number of carry chunks. Range 1..WIDTH. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- op  input  1  0 = ADD, 1 = SUB (a - b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result beat.
- c  output  WIDTH+1  result. ADD: bit WIDTH = carry out. SUB: two's-complement difference, bit WIDTH = borrow.
- sat  output  1  saturation flag for the current result beat (see Optional Feature).

Behaviour:
- Reset, one clk edge with reset=1:
  - all stage valid bits cleared; out_valid=0, c=0, sat=0.
  - in_ready=0 while reset is high.
  - Data registers other than c need no reset.
- Advance enable: en = !out_valid || out_ready. All stages advance together on en; there is no bubble collapsing.
- in_ready = en && !reset (combinational). A beat is accepted when in_valid && in_ready.
- Stage 0 captures accepted a, b, op. Its valid bit = in_valid && in_ready. When en=1 and no beat is accepted, a bubble (valid=0) enters.
- Arithmetic for SUB: use b' = ~b with carry-in 1. For ADD: b' = b with carry-in 0.
- Stage k (0..STAGES-1):
  - computes chunk k: {cout_k, sum_k} = a[k] + b'[k] + cin_k, where cin_0 = op.
  - registers sum_k and cout_k.
  - delays the remaining upper operand chunks unchanged (staircase).
  - carries forward previously finished lower sum chunks.
- Final result, raw:
  - ADD: c = {cout_last, sum}.
  - SUB: c = {~cout_last, sum}, where bit WIDTH = borrow.
- Latency: exactly STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 beat per cycle.
- Stall: while out_valid && !out_ready:
  - every stage register holds.
  - c, sat and out_valid are stable.
  - in_ready=0.
- Ordering: results leave in acceptance order. No loss, no duplication.
- Reset mid-operation: all in-flight beats are discarded. out_valid=0 on the cycle after the reset edge; none of the discarded beats ever appear.
- STAGES=1: a single registered full adder, latency 1.
- Wrap-around:
  - ADD of all-ones with all-ones gives c = {1, all-ones minus 1}.
  - SUB with a==b gives c=0.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined:
  - ADD with carry: c = {1'b0, {WIDTH{1'b1}}}, sat=1.
  - SUB with borrow: c = 0, sat=1.
  - Otherwise c = raw result with c[WIDTH]=0, sat=0.
  - The clamp is applied in the final stage and adds no latency.
- Undefined: c = raw result, and sat is tied to 0.

Decomposition:
- Package adder_pipe_pkg:
  - op_e enum (OP_ADD=1'b0, OP_SUB=1'b1).
  - function chunk_w(WIDTH, STAGES).
  - elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_pipe_stage:
  - one CHUNK-bit add with carry in/out.
  - registered sum, carry, valid and delayed upper operands.
  - enable and reset inputs.
  - instantiated STAGES times in a generate loop.
- Top level holds the handshake logic, the final result assembly and the SAT clamp.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- Reset, then ADD a=200 b=100 with out_ready=1 -> out_valid after 2 cycles, c=9'h12C, sat=0.
- ADD 8'h0F+8'h01 -> c=9'h010, proving the carry crosses chunk 0 -> 1. SUB 5-9 -> c=9'h1FC (borrow=1). SUB 7-7 -> c=0.
- Stream 4 beats (1+1, 2+2, 3+3, 4+4), out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, c stable; outputs 2,4,6,8 in order with no duplicates.
- Two beats in flight, then assert reset for 1 cycle -> out_valid=0 the next cycle, neither result ever emerges, c=0; in_ready=1 after reset deasserts.
- WIDTH=16, STAGES=4, ADD 16'hFFFF+16'h0001 with out_ready=1 -> c=17'h10000 exactly 4 cycles after acceptance. STAGES=1 -> latency 1.
- With ADDER_PIPE_SAT_EN defined:
  - 200+100 -> c=9'h0FF, sat=1.
  - 5-9 -> c=0, sat=1.
  - 3+4 -> c=7, sat=0.
